// File: rtl/wb_sched.sv
// Write-back scheduler: per-register pending-write scoreboard with a RAW/overflow stall,
// plus a single write-port arbiter (hold > mem > ex) with a one-entry hold buffer for ex.

module wb_sched_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt
);
  // Saturates at both ends; simultaneous inc/dec cancels out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              cnt <= 2'd0;
    else if (inc && !dec && cnt != 2'd3)   cnt <= cnt + 2'd1;
    else if (dec && !inc && cnt != 2'd0)   cnt <= cnt - 2'd1;
  end
endmodule

module wb_sched #(
  parameter int N_REG  = 16,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_i,
  input  logic [3:0]        issue_r_i,
  input  logic [3:0]        src0_r_i,
  input  logic [3:0]        src1_r_i,
  input  logic [1:0]        src_en_i,
  input  logic              stall_i,
  output logic              stall_o,
  input  logic              ex_req_i,
  input  logic [3:0]        ex_r_i,
  input  logic [W_DATA-1:0] ex_data_i,
  output logic              ex_ack_o,
  input  logic              mem_req_i,
  input  logic [3:0]        mem_r_i,
  input  logic [W_DATA-1:0] mem_data_i,
  output logic              mem_ack_o,
  output logic              wb_o,
  output logic [3:0]        wb_r_o,
  output logic [W_DATA-1:0] wb_data_o,
  output logic [N_REG-1:0]  busy_o
);

  typedef struct packed {
    logic              v;
    logic [3:0]        r;
    logic [W_DATA-1:0] d;
  } wr_t;

  logic [N_REG-1:0][1:0] cnt;
  logic [N_REG-1:0]      inc, dec, full;
  logic                  accept, hazard;
  logic                  src0_busy, src1_busy, dst_full;
  wr_t                   hold, hold_nxt, wb_nxt;

  assign accept = issue_i & ~stall_o;

  for (genvar gi = 0; gi < N_REG; gi++) begin : g_reg
    assign inc[gi]    = accept && (issue_r_i == 4'(gi));
    assign dec[gi]    = wb_o && (wb_r_o == 4'(gi));
    assign busy_o[gi] = |cnt[gi];
    assign full[gi]   = &cnt[gi];
    wb_sched_cnt u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc[gi]),
      .dec (dec[gi]),
      .cnt (cnt[gi])
    );
  end

  always_comb begin
    src0_busy = 1'b0;
    src1_busy = 1'b0;
    dst_full  = 1'b0;
    for (int i = 0; i < N_REG; i++) begin
      if (src0_r_i == 4'(i))  src0_busy = busy_o[i];
      if (src1_r_i == 4'(i))  src1_busy = busy_o[i];
      if (issue_r_i == 4'(i)) dst_full  = full[i];
    end
  end

  // An ex result that cannot be acked this cycle would otherwise race the new issue.
  assign hazard  = (src_en_i[0] & src0_busy) | (src_en_i[1] & src1_busy) |
                   (issue_i & dst_full) | (issue_i & hold.v & ex_req_i);
  assign stall_o = stall_i | hazard;

  assign mem_ack_o = rst & mem_req_i & ~hold.v;
  assign ex_ack_o  = rst & ex_req_i & ~hold.v;

  always_comb begin
    wb_nxt   = '0;
    hold_nxt = hold;
    if (hold.v) begin
      wb_nxt   = hold;
      hold_nxt = '0;
    end else if (mem_req_i) begin
      wb_nxt = '{v: 1'b1, r: mem_r_i, d: mem_data_i};
      if (ex_req_i) hold_nxt = '{v: 1'b1, r: ex_r_i, d: ex_data_i};
    end else if (ex_req_i) begin
      wb_nxt = '{v: 1'b1, r: ex_r_i, d: ex_data_i};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      wb_o      <= 1'b0;
      wb_r_o    <= 4'd0;
      wb_data_o <= '0;
    end else begin
      hold      <= hold_nxt;
      wb_o      <= wb_nxt.v;
      wb_r_o    <= wb_nxt.r;
      wb_data_o <= wb_nxt.d;
    end
  end

endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched: scoreboard stalls, saturation, arbitration and reset.

module tb_wb_sched;
  localparam int N_REG  = 16;
  localparam int W_DATA = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_i;
  logic [3:0]        issue_r_i, src0_r_i, src1_r_i;
  logic [1:0]        src_en_i;
  logic              stall_i, stall_o;
  logic              ex_req_i, mem_req_i, ex_ack_o, mem_ack_o;
  logic [3:0]        ex_r_i, mem_r_i;
  logic [W_DATA-1:0] ex_data_i, mem_data_i;
  logic              wb_o;
  logic [3:0]        wb_r_o;
  logic [W_DATA-1:0] wb_data_o;
  logic [N_REG-1:0]  busy_o;

  int tests = 0;
  int fails = 0;

  wb_sched #(.N_REG(N_REG), .W_DATA(W_DATA)) dut (
    .clk(clk), .rst(rst),
    .issue_i(issue_i), .issue_r_i(issue_r_i),
    .src0_r_i(src0_r_i), .src1_r_i(src1_r_i), .src_en_i(src_en_i),
    .stall_i(stall_i), .stall_o(stall_o),
    .ex_req_i(ex_req_i), .ex_r_i(ex_r_i), .ex_data_i(ex_data_i), .ex_ack_o(ex_ack_o),
    .mem_req_i(mem_req_i), .mem_r_i(mem_r_i), .mem_data_i(mem_data_i), .mem_ack_o(mem_ack_o),
    .wb_o(wb_o), .wb_r_o(wb_r_o), .wb_data_o(wb_data_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One-cycle ex request with an empty hold buffer; returns just after the granting edge.
  task automatic drive_ex(input logic [3:0] r, input logic [W_DATA-1:0] d);
    ex_req_i = 1'b1; ex_r_i = r; ex_data_i = d;
    step();
    ex_req_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    issue_i = 0; issue_r_i = 0; src0_r_i = 0; src1_r_i = 0; src_en_i = 0; stall_i = 0;
    ex_req_i = 0; ex_r_i = 0; ex_data_i = 0; mem_req_i = 0; mem_r_i = 0; mem_data_i = 0;
    step(); step();
    mem_req_i = 1'b1; ex_req_i = 1'b1; mem_r_i = 4'd2; mem_data_i = 32'hDEAD;
    #1;
    tests++; if (mem_ack_o !== 1'b0 || ex_ack_o !== 1'b0) begin fails++;
      $display("FAIL reset_ack: mem_ack=%b ex_ack=%b expected 0 0", mem_ack_o, ex_ack_o); end
    step();
    tests++; if (wb_o !== 1'b0 || wb_r_o !== 4'd0 || wb_data_o !== 32'd0 || busy_o !== 16'd0) begin fails++;
      $display("FAIL reset_state: wb_o=%b r=%0d d=%h busy=%h expected all 0", wb_o, wb_r_o, wb_data_o, busy_o); end
    mem_req_i = 1'b0; ex_req_i = 1'b0;
    rst = 1'b1;
    step();
    tests++; if (wb_o !== 1'b0) begin fails++;
      $display("FAIL reset_release_idle: wb_o=%b expected 0", wb_o); end
  endtask

  task automatic test_issue_wb;
    issue_i = 1'b1; issue_r_i = 4'd3;
    #1;
    tests++; if (stall_o !== 1'b0) begin fails++;
      $display("FAIL issue_r3_stall: stall_o=%b expected 0", stall_o); end
    step();
    issue_i = 1'b0;
    tests++; if (busy_o[3] !== 1'b1) begin fails++;
      $display("FAIL issue_r3_busy: busy_o[3]=%b expected 1", busy_o[3]); end
    step();
    ex_req_i = 1'b1; ex_r_i = 4'd3; ex_data_i = 32'h11;
    #1;
    tests++; if (ex_ack_o !== 1'b1) begin fails++;
      $display("FAIL ex_ack_r3: ex_ack_o=%b expected 1", ex_ack_o); end
    step();
    ex_req_i = 1'b0;
    tests++; if (wb_o !== 1'b1 || wb_r_o !== 4'd3 || wb_data_o !== 32'h11 || busy_o[3] !== 1'b1) begin fails++;
      $display("FAIL wb_r3: wb_o=%b r=%0d d=%h busy3=%b expected 1 3 11 1", wb_o, wb_r_o, wb_data_o, busy_o[3]); end
    step();
    tests++; if (wb_o !== 1'b0 || busy_o[3] !== 1'b0) begin fails++;
      $display("FAIL retire_r3: wb_o=%b busy3=%b expected 0 0", wb_o, busy_o[3]); end
  endtask

  task automatic test_raw_stall;
    issue_i = 1'b1; issue_r_i = 4'd5;
    step();
    issue_r_i = 4'd6; src0_r_i = 4'd5; src_en_i = 2'b01;
    #1;
    tests++; if (stall_o !== 1'b1) begin fails++;
      $display("FAIL raw_stall_start: stall_o=%b expected 1", stall_o); end
    step();
    ex_req_i = 1'b1; ex_r_i = 4'd5; ex_data_i = 32'h55;
    #1;
    tests++; if (stall_o !== 1'b1 || ex_ack_o !== 1'b1) begin fails++;
      $display("FAIL raw_stall_hold: stall_o=%b ex_ack=%b expected 1 1", stall_o, ex_ack_o); end
    step();
    ex_req_i = 1'b0;
    tests++; if (wb_o !== 1'b1 || wb_r_o !== 4'd5 || stall_o !== 1'b1) begin fails++;
      $display("FAIL raw_wb_cycle: wb_o=%b r=%0d stall=%b expected 1 5 1", wb_o, wb_r_o, stall_o); end
    step();
    tests++; if (stall_o !== 1'b0) begin fails++;
      $display("FAIL raw_release: stall_o=%b expected 0", stall_o); end
    step();
    issue_i = 1'b0; src_en_i = 2'b00;
    tests++; if (busy_o[6] !== 1'b1 || busy_o[5] !== 1'b0) begin fails++;
      $display("FAIL raw_accept_r6: busy6=%b busy5=%b expected 1 0", busy_o[6], busy_o[5]); end
    // downstream stall must block issue but not retirement
    stall_i = 1'b1; issue_i = 1'b1; issue_r_i = 4'd9;
    drive_ex(4'd6, 32'h66);
    tests++; if (wb_o !== 1'b1 || wb_r_o !== 4'd6 || stall_o !== 1'b1) begin fails++;
      $display("FAIL stall_i_wb: wb_o=%b r=%0d stall=%b expected 1 6 1", wb_o, wb_r_o, stall_o); end
    step();
    tests++; if (busy_o !== 16'd0) begin fails++;
      $display("FAIL stall_i_retire: busy=%h expected 0000", busy_o); end
    stall_i = 1'b0; issue_i = 1'b0;
  endtask

  task automatic test_arb;
    ex_req_i = 1'b1; ex_r_i = 4'd1; ex_data_i = 32'hA;
    mem_req_i = 1'b1; mem_r_i = 4'd2; mem_data_i = 32'hB;
    #1;
    tests++; if (mem_ack_o !== 1'b1 || ex_ack_o !== 1'b1) begin fails++;
      $display("FAIL arb_both_ack: mem_ack=%b ex_ack=%b expected 1 1", mem_ack_o, ex_ack_o); end
    step();
    mem_req_i = 1'b1; mem_r_i = 4'd9; mem_data_i = 32'hE;
    ex_r_i = 4'd8; ex_data_i = 32'hC;
    issue_i = 1'b1; issue_r_i = 4'd10;
    #1;
    tests++; if (wb_o !== 1'b1 || wb_r_o !== 4'd2 || wb_data_o !== 32'hB) begin fails++;
      $display("FAIL arb_wb_mem: wb_o=%b r=%0d d=%h expected 1 2 b", wb_o, wb_r_o, wb_data_o); end
    tests++; if (ex_ack_o !== 1'b0 || mem_ack_o !== 1'b0 || stall_o !== 1'b1) begin fails++;
      $display("FAIL arb_hold_block: ex_ack=%b mem_ack=%b stall=%b expected 0 0 1", ex_ack_o, mem_ack_o, stall_o); end
    step();
    issue_i = 1'b0; mem_req_i = 1'b0;
    #1;
    tests++; if (wb_o !== 1'b1 || wb_r_o !== 4'd1 || wb_data_o !== 32'hA || ex_ack_o !== 1'b1) begin fails++;
      $display("FAIL arb_wb_hold: wb_o=%b r=%0d d=%h ex_ack=%b expected 1 1 a 1", wb_o, wb_r_o, wb_data_o, ex_ack_o); end
    step();
    ex_req_i = 1'b0;
    tests++; if (wb_o !== 1'b1 || wb_r_o !== 4'd8 || wb_data_o !== 32'hC) begin fails++;
      $display("FAIL arb_wb_ex: wb_o=%b r=%0d d=%h expected 1 8 c", wb_o, wb_r_o, wb_data_o); end
    step();
    tests++; if (wb_o !== 1'b0 || busy_o !== 16'd0) begin fails++;
      $display("FAIL arb_idle: wb_o=%b busy=%h expected 0 0000", wb_o, busy_o); end
  endtask

  task automatic test_full;
    issue_i = 1'b1; issue_r_i = 4'd7;
    step(); step(); step();
    #1;
    tests++; if (stall_o !== 1'b1 || busy_o[7] !== 1'b1) begin fails++;
      $display("FAIL full_stall: stall=%b busy7=%b expected 1 1", stall_o, busy_o[7]); end
    step();
    ex_req_i = 1'b1; ex_r_i = 4'd7; ex_data_i = 32'h77;
    step();
    ex_req_i = 1'b0;
    tests++; if (wb_o !== 1'b1 || stall_o !== 1'b1) begin fails++;
      $display("FAIL full_wb: wb_o=%b stall=%b expected 1 1", wb_o, stall_o); end
    step();
    tests++; if (stall_o !== 1'b0) begin fails++;
      $display("FAIL full_release: stall=%b expected 0", stall_o); end
    step();
    #1;
    tests++; if (stall_o !== 1'b1) begin fails++;
      $display("FAIL full_again: stall=%b expected 1 (cnt back at 3)", stall_o); end
    issue_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    ex_req_i = 1'b1; ex_r_i = 4'd7; ex_data_i = 32'h100;
    step();
    ex_data_i = 32'h101;
    tests++; if (wb_o !== 1'b1 || wb_data_o !== 32'h100) begin fails++;
      $display("FAIL b2b_0: wb_o=%b d=%h expected 1 100", wb_o, wb_data_o); end
    step();
    ex_data_i = 32'h102;
    tests++; if (wb_o !== 1'b1 || wb_data_o !== 32'h101 || busy_o[7] !== 1'b1) begin fails++;
      $display("FAIL b2b_1: wb_o=%b d=%h busy7=%b expected 1 101 1", wb_o, wb_data_o, busy_o[7]); end
    step();
    ex_req_i = 1'b0;
    tests++; if (wb_o !== 1'b1 || wb_data_o !== 32'h102) begin fails++;
      $display("FAIL b2b_2: wb_o=%b d=%h expected 1 102", wb_o, wb_data_o); end
    step();
    tests++; if (wb_o !== 1'b0 || busy_o[7] !== 1'b0) begin fails++;
      $display("FAIL b2b_drain: wb_o=%b busy7=%b expected 0 0", wb_o, busy_o[7]); end
  endtask

  task automatic test_same_cycle;
    issue_i = 1'b1; issue_r_i = 4'd4;
    step();
    issue_i = 1'b0;
    drive_ex(4'd4, 32'h44);
    issue_i = 1'b1;
    #1;
    tests++; if (wb_o !== 1'b1 || wb_r_o !== 4'd4 || stall_o !== 1'b0) begin fails++;
      $display("FAIL same_setup: wb_o=%b r=%0d stall=%b expected 1 4 0", wb_o, wb_r_o, stall_o); end
    step();
    issue_i = 1'b0;
    tests++; if (busy_o[4] !== 1'b1 || wb_o !== 1'b0) begin fails++;
      $display("FAIL same_cycle_cnt: busy4=%b wb_o=%b expected 1 0", busy_o[4], wb_o); end
    drive_ex(4'd4, 32'h45);
    step();
    tests++; if (busy_o[4] !== 1'b0) begin fails++;
      $display("FAIL same_drain: busy4=%b expected 0 (cnt must have stayed 1)", busy_o[4]); end
  endtask

  task automatic test_reset_mid;
    issue_i = 1'b1; issue_r_i = 4'd13;
    ex_req_i = 1'b1; ex_r_i = 4'd11; ex_data_i = 32'hBB;
    mem_req_i = 1'b1; mem_r_i = 4'd12; mem_data_i = 32'hCC;
    step();
    issue_i = 1'b0; ex_req_i = 1'b0; mem_req_i = 1'b0;
    tests++; if (wb_o !== 1'b1 || wb_r_o !== 4'd12 || busy_o[13] !== 1'b1) begin fails++;
      $display("FAIL mid_setup: wb_o=%b r=%0d busy13=%b expected 1 12 1", wb_o, wb_r_o, busy_o[13]); end
    rst = 1'b0;
    mem_req_i = 1'b1;
    #1;
    tests++; if (wb_o !== 1'b0 || wb_r_o !== 4'd0 || wb_data_o !== 32'd0 || busy_o !== 16'd0 || mem_ack_o !== 1'b0) begin fails++;
      $display("FAIL mid_reset: wb_o=%b r=%0d d=%h busy=%h mem_ack=%b expected all 0", wb_o, wb_r_o, wb_data_o, busy_o, mem_ack_o); end
    mem_req_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    tests++; if (wb_o !== 1'b0) begin fails++;
      $display("FAIL mid_post_1: wb_o=%b expected 0 (held entry discarded)", wb_o); end
    step();
    tests++; if (wb_o !== 1'b0 || busy_o !== 16'd0) begin fails++;
      $display("FAIL mid_post_2: wb_o=%b busy=%h expected 0 0000", wb_o, busy_o); end
  endtask

  initial begin
    test_reset();
    test_issue_wb();
    test_raw_stall();
    test_arb();
    test_full();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
